// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Package  : audio_pkg
// Brief    : Shared audio sample types and I2S frame geometry helpers.
// Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W_DEFAULT = 32;
    localparam int I2S_SLOTS        = 2 * SAMPLE_W_DEFAULT;

    typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    // Bit slots in one stereo frame for a given channel width.
    function automatic int i2s_slots(input int sample_w);
        return 2 * sample_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : i2s_clk_gen
// Brief    : Divides the system clock into BCLK and flags the 1->0 BCLK edge.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_clk_gen #(
    parameter int BCLK_DIV = 8
) (
    input  logic clock,
    input  logic reset,
    output logic i2s_bclk,
    output logic fall_strobe
);

    localparam int                c_div_w    = $clog2(BCLK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);

    logic [c_div_w-1:0] r_div;
    logic               r_bclk;
    logic               w_terminal;

    assign w_terminal  = (r_div == c_div_last);
    assign fall_strobe = w_terminal && r_bclk;
    assign i2s_bclk    = r_bclk;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_terminal) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Brief    : Stereo Philips-I2S transmitter with a single-entry sample hold.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 8,
    parameter int SAMPLE_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] audio_in_L,
    input  logic signed [SAMPLE_W-1:0] audio_in_R,
    input  logic                       audio_valid,
    output logic                       audio_ready,
    output logic                       i2s_bclk,
    output logic                       i2s_lrck,
    output logic                       i2s_data,
    output logic                       frame_start,
    output logic                       underrun
);

    localparam int                  c_slots       = i2s_slots(SAMPLE_W);
    localparam int                  c_slot_w      = $clog2(c_slots);
    localparam logic [c_slot_w-1:0] c_last_slot   = c_slot_w'(c_slots - 1);
    localparam logic [c_slot_w-1:0] c_right_first = c_slot_w'(SAMPLE_W);

    logic                   w_fall_strobe;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_hold_full_next;
    logic [c_slot_w-1:0]    w_slot_next;

    logic                   r_hold_full;
    logic                   r_ready;
    logic [c_slots-1:0]     r_hold;
    logic [c_slots-1:0]     r_shift;
    logic [c_slot_w-1:0]    r_slot;
    logic                   r_lrck;
    logic                   r_data;
    logic                   r_frame_start;
    logic                   r_underrun;

    i2s_clk_gen #(
        .BCLK_DIV    (BCLK_DIV)
    ) u_clk_gen (
        .clock       (clock),
        .reset       (reset),
        .i2s_bclk    (i2s_bclk),
        .fall_strobe (w_fall_strobe)
    );

    // r_ready always mirrors !r_hold_full, so an accept never coincides with a full hold.
    assign w_accept         = audio_valid && r_ready;
    assign w_load           = w_fall_strobe && (r_slot == c_last_slot);
    assign w_hold_full_next = w_accept || (r_hold_full && !w_load);
    assign w_slot_next      = (r_slot == c_last_slot) ? '0 : r_slot + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_full   <= 1'b0;
            r_ready       <= 1'b0;
            r_hold        <= '0;
            r_shift       <= '0;
            r_slot        <= c_last_slot;
            r_lrck        <= 1'b0;
            r_data        <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_hold_full   <= w_hold_full_next;
            r_ready       <= !w_hold_full_next;
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_hold_full;
            if (w_accept) begin
                r_hold <= {audio_in_L, audio_in_R};
            end
            // Shifting out the MSB on every fall gives the one-BCLK delay after LRCK.
            if (w_fall_strobe) begin
                r_slot <= w_slot_next;
                r_lrck <= (w_slot_next >= c_right_first);
                r_data <= r_shift[c_slots-1];
                if (w_load) begin
                    r_shift <= r_hold_full ? r_hold : '0;
                end else begin
                    r_shift <= {r_shift[c_slots-2:0], 1'b0};
                end
            end
        end
    end

    assign audio_ready = r_ready;
    assign i2s_lrck    = r_lrck;
    assign i2s_data    = r_data;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Brief    : Scoreboard bench for i2s_tx (32-bit/div-2 and 16-bit/div-8 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Primary DUT: BCLK_DIV=2, SAMPLE_W=32
    logic        reset;
    logic [31:0] audio_in_L, audio_in_R;
    logic        audio_valid, audio_ready;
    logic        i2s_bclk, i2s_lrck, i2s_data, frame_start, underrun;

    // Secondary DUT: BCLK_DIV=8, SAMPLE_W=16
    logic        reset2;
    logic [15:0] l2, r2;
    logic        valid2, ready2, bclk2, lrck2, data2, fs2, ur2;

    i2s_tx #(.BCLK_DIV(2), .SAMPLE_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .audio_in_L  (audio_in_L),
        .audio_in_R  (audio_in_R),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_data    (i2s_data),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    i2s_tx #(.BCLK_DIV(8), .SAMPLE_W(16)) dut2 (
        .clock       (clock),
        .reset       (reset2),
        .audio_in_L  (l2),
        .audio_in_R  (r2),
        .audio_valid (valid2),
        .audio_ready (ready2),
        .i2s_bclk    (bclk2),
        .i2s_lrck    (lrck2),
        .i2s_data    (data2),
        .frame_start (fs2),
        .underrun    (ur2)
    );

    typedef struct {
        logic [63:0] word;
        logic        urun;
    } exp_t;

    exp_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int words_checked = 0;
    int frames_seen   = 0;
    int mon_slot      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [63:0] word, input logic urun);
        exp_t e;
        e.word = word;
        e.urun = urun;
        exp_q.push_back(e);
    endtask

    // Monitor: reassembles each frame word from the serial stream.
    logic        rst_q = 1'b1;
    logic        prev_bclk = 1'b0;
    logic        cur_v = 1'b0, prev_v = 1'b0;
    logic [63:0] cur_exp, prev_exp, asm_cur, asm_prev;
    exp_t        mon_e;

    always @(posedge clock) rst_q <= reset;

    always @(negedge clock) begin
        if (rst_q) begin
            mon_slot  = 0;
            cur_v     = 1'b0;
            prev_v    = 1'b0;
            prev_bclk = 1'b0;
            asm_cur   = '0;
            asm_prev  = '0;
        end else begin
            if (frame_start) begin
                frames_seen++;
                prev_v   = cur_v;
                prev_exp = cur_exp;
                asm_prev = asm_cur;
                asm_cur  = '0;
                mon_slot = 0;
                check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                cur_v = 1'b0;
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("underrun", 64'(underrun), 64'(mon_e.urun));
                    if (!mon_e.urun) check("ready_after_load", 64'(audio_ready), 64'd1);
                    cur_exp = mon_e.word;
                    cur_v   = 1'b1;
                end
            end
            if (i2s_bclk && !prev_bclk && mon_slot < 64) begin
                check("lrck", 64'(i2s_lrck), 64'(mon_slot >= 32));
                if (mon_slot == 0) begin
                    if (prev_v) begin
                        asm_prev[0] = i2s_data;
                        check("frame_word", asm_prev, prev_exp);
                        words_checked++;
                        prev_v = 1'b0;
                    end
                end else begin
                    asm_cur[64 - mon_slot] = i2s_data;
                end
                mon_slot++;
            end
            prev_bclk = i2s_bclk;
        end
    end

    // Called at a negedge; returns at the negedge where reset is released.
    task automatic do_reset(input bit chk);
        reset       = 1'b1;
        audio_valid = 1'b0;
        @(negedge clock);
        if (chk) check("reset_outputs",
                       64'({i2s_bclk, i2s_lrck, i2s_data, frame_start, underrun, audio_ready}), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
        int n = 0;
        audio_in_L  = l;
        audio_in_R  = r;
        audio_valid = 1'b1;
        while (!audio_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("send_timeout", 64'(n < 2000), 64'd1);
        @(negedge clock);
        check("ready_drop", 64'(audio_ready), 64'd0);
    endtask

    task automatic wait_words(input int target);
        int n = 0;
        while (words_checked < target && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("words_timeout", 64'(words_checked >= target), 64'd1);
    endtask

    // First fall 4 cycles after release; optionally one full 256-cycle frame period.
    task automatic timing_check(input bit full);
        int fs_cnt = 0;
        repeat (3) @(negedge clock);
        check("bclk_before_fall", 64'(i2s_bclk), 64'd1);
        check("no_early_frame", 64'(frame_start), 64'd0);
        @(negedge clock);
        check("first_frame_start", 64'(frame_start), 64'd1);
        check("bclk_after_fall", 64'(i2s_bclk), 64'd0);
        if (full) begin
            repeat (255) begin
                @(negedge clock);
                if (frame_start) fs_cnt++;
            end
            check("no_frame_within_period", 64'(fs_cnt), 64'd0);
            @(negedge clock);
            check("frame_period_256", 64'(frame_start), 64'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int f0;
        int n;
        int k;
        int cyc;
        logic        prevb;
        logic        exp_bit;
        logic [31:0] w2;

        reset = 1'b1; reset2 = 1'b1;
        audio_valid = 1'b0; audio_in_L = '0; audio_in_R = '0;
        valid2 = 1'b0; l2 = '0; r2 = '0;
        repeat (2) @(negedge clock);

        // 1: idle stream, silence frames with underrun
        do_reset(1'b1);
        base = words_checked;
        push(64'h0, 1'b1); push(64'h0, 1'b1); push(64'h0, 1'b1);
        timing_check(1'b1);
        wait_words(base + 2);
        check("queue_drained_t1", 64'(exp_q.size()), 64'd0);

        // 2: one pair before the first load
        do_reset(1'b0);
        base = words_checked;
        push({32'h8000_0001, 32'h7FFF_FFFE}, 1'b0);
        push(64'h0, 1'b1);
        send_pair(32'h8000_0001, 32'h7FFF_FFFE);
        audio_valid = 1'b0;
        wait_words(base + 1);
        check("queue_drained_t2", 64'(exp_q.size()), 64'd0);

        // 3: back-to-back pairs under backpressure
        do_reset(1'b0);
        base = words_checked;
        push({32'h1234_5678, 32'h9ABC_DEF0}, 1'b0);
        push({32'hFFFF_FFFF, 32'h0000_0000}, 1'b0);
        push({32'hDEAD_BEEF, 32'hCAFE_F00D}, 1'b0);
        push(64'h0, 1'b1);
        send_pair(32'h1234_5678, 32'h9ABC_DEF0);
        send_pair(32'hFFFF_FFFF, 32'h0000_0000);
        send_pair(32'hDEAD_BEEF, 32'hCAFE_F00D);
        audio_valid = 1'b0;
        wait_words(base + 3);
        check("queue_drained_t3", 64'(exp_q.size()), 64'd0);

        // 4: valid on the load cycle itself with an empty hold
        do_reset(1'b0);
        base = words_checked;
        push(64'h0, 1'b1);
        push({32'h0F0F_0F0F, 32'hF0F0_F0F0}, 1'b0);
        push(64'h0, 1'b1);
        repeat (3) @(negedge clock);
        check("t4_bclk_high", 64'(i2s_bclk), 64'd1);
        audio_in_L = 32'h0F0F_0F0F; audio_in_R = 32'hF0F0_F0F0; audio_valid = 1'b1;
        @(negedge clock);
        check("t4_frame_start", 64'(frame_start), 64'd1);
        check("t4_underrun", 64'(underrun), 64'd1);
        check("t4_accepted", 64'(audio_ready), 64'd0);
        audio_valid = 1'b0;
        wait_words(base + 2);
        check("queue_drained_t4", 64'(exp_q.size()), 64'd0);

        // 5: reset in slot 45 discards the held pair
        do_reset(1'b0);
        f0 = frames_seen;
        push({32'h1111_2222, 32'h3333_4444}, 1'b0);
        send_pair(32'h1111_2222, 32'h3333_4444);
        audio_valid = 1'b0;
        send_pair(32'h5555_6666, 32'h7777_8888);
        audio_valid = 1'b0;
        n = 0;
        while (!(frames_seen > f0 && mon_slot == 46) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("t5_reach_slot45", 64'(n < 1000), 64'd1);
        check("t5_right_slot", 64'(i2s_lrck), 64'd1);
        check("t5_hold_full", 64'(audio_ready), 64'd0);
        check("queue_drained_t5a", 64'(exp_q.size()), 64'd0);
        do_reset(1'b1);
        base = words_checked;
        push(64'h0, 1'b1); push(64'h0, 1'b1);
        timing_check(1'b0);
        wait_words(base + 1);
        check("queue_drained_t5b", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;

        // 6: 16-bit build, BCLK_DIV=8, bit-exact at every BCLK rise
        reset2 = 1'b1;
        @(negedge clock);
        check("reset2_outputs", 64'({bclk2, lrck2, data2, fs2, ur2, ready2}), 64'd0);
        reset2 = 1'b0;
        l2 = 16'hA5A5; r2 = 16'h1234; valid2 = 1'b1;
        n = 0;
        while (!ready2 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("ready2_drop", 64'(ready2), 64'd0);
        valid2 = 1'b0;
        n = 0;
        while (!fs2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("fs2_seen", 64'(fs2), 64'd1);
        check("underrun2_first", 64'(ur2), 64'd0);
        w2 = 32'hA5A5_1234;
        k = 0; cyc = 0; prevb = bclk2;
        while (k <= 32 && cyc < 1200) begin
            @(negedge clock);
            cyc++;
            if (fs2) begin
                check("frame2_period", 64'(cyc), 64'd512);
                check("underrun2_second", 64'(ur2), 64'd1);
            end
            if (bclk2 && !prevb) begin
                check("lrck2", 64'(lrck2), 64'((k % 32) >= 16));
                exp_bit = (k == 0) ? 1'b0 : w2[(32 - k) % 32];
                check("data2_bit", 64'(data2), 64'(exp_bit));
                k++;
            end
            prevb = bclk2;
        end
        check("data2_done", 64'(k), 64'd33);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
